// File: rtl/lotr_pkg.sv
// Shared opcode constants and FSM state types for the LOTR UART command receiver.
package lotr_pkg;

  localparam logic [7:0] UART_OPC_WRITE = 8'h57;
  localparam logic [7:0] UART_OPC_READ  = 8'h52;

  // Both state sets live in one package, so the members carry a prefix to stay unique.
  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP,
    BIT_WAIT_HIGH
  } t_uart_bit_st;

  typedef enum logic [1:0] {
    CMD_OPC,
    CMD_ADDR,
    CMD_DATA,
    CMD_ISSUE
  } t_uart_cmd_st;

endpackage

// File: rtl/lotr_uart_cmd_rx_if.sv
// Command request channel (valid/ready) from the UART command receiver to the MMIO path.
interface lotr_uart_cmd_rx_if;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdWrite;
  logic [31:0] CmdAddress;
  logic [31:0] CmdData;

  modport master (
    output CmdValid,
    output CmdWrite,
    output CmdAddress,
    output CmdData,
    input  CmdReady
  );

  modport slave (
    input  CmdValid,
    input  CmdWrite,
    input  CmdAddress,
    input  CmdData,
    output CmdReady
  );
endinterface

// File: rtl/lotr_uart_rx_byte.sv
// 8N1 LSB-first UART byte deserializer: input synchronizer, byte FSM and bit/clock counters.
module lotr_uart_rx_byte
  import lotr_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       QClk,
  input  logic       RstQnnnH,
  input  logic       UartRx,
  output logic       RxByteValid,
  output logic [7:0] RxByte,
  output logic       FrameErr
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

  t_uart_bit_st state, state_nxt;
  logic        rx_meta, rx_sync, rx_prev;
  logic [2:0]  warm;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        cnt_clr, shift_en, byte_done, frame_bad;

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      warm        <= '0;
      state       <= BIT_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      RxByteValid <= 1'b0;
      RxByte      <= '0;
      FrameErr    <= 1'b0;
    end else begin
      rx_meta     <= UartRx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      warm        <= {warm[1:0], 1'b1};
      state       <= state_nxt;
      RxByteValid <= 1'b0;
      FrameErr    <= 1'b0;
      if (cnt_clr) clk_cnt <= '0;
      else         clk_cnt <= clk_cnt + 16'd1;
      if (state == BIT_IDLE) bit_cnt <= '0;
      if (shift_en) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        RxByteValid <= 1'b1;
        RxByte      <= shift;
      end
      if (frame_bad) FrameErr <= 1'b1;
    end
  end

  // warm[1]: rx_sync now reflects the real line; warm[2]: rx_prev does too.
  // A low line without a genuine post-reset high->low edge means we came out of
  // reset mid-frame, so resynchronise instead of starting a byte.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (state)
      BIT_IDLE: begin
        cnt_clr = 1'b1;
        if (warm[1] && !rx_sync)
          state_nxt = (warm[2] && rx_prev) ? BIT_START : BIT_WAIT_HIGH;
      end
      BIT_START: begin
        if (clk_cnt == HALF_M1) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_sync ? BIT_IDLE : BIT_DATA;
        end
      end
      BIT_DATA: begin
        if (clk_cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = BIT_STOP;
        end
      end
      BIT_STOP: begin
        if (clk_cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (rx_sync) begin
            byte_done = 1'b1;
            state_nxt = BIT_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = BIT_WAIT_HIGH;
          end
        end
      end
      BIT_WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rx_sync) state_nxt = BIT_IDLE;
      end
      default: state_nxt = BIT_IDLE;
    endcase
  end

endmodule

// File: rtl/lotr_uart_cmd_rx.sv
// UART terminal command receiver: parses 'W'/'R' frames into one valid/ready request each.
module lotr_uart_cmd_rx
  import lotr_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                       QClk,
  input  logic                       RstQnnnH,
  input  logic                       UartRx,
  lotr_uart_cmd_rx_if.master         cmd,
  output logic                       RxByteValid,
  output logic [7:0]                 RxByte,
  output logic                       FrameErr,
  output logic                       CmdErr
);

  t_uart_cmd_st state, state_nxt;
  logic [1:0]  byte_cnt;
  logic        is_write;
  logic [31:0] addr_q, data_q;
  logic        wr_load, wr_val, addr_shift, data_shift, data_clr, err_set;

  lotr_uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .QClk       (QClk),
    .RstQnnnH   (RstQnnnH),
    .UartRx     (UartRx),
    .RxByteValid(RxByteValid),
    .RxByte     (RxByte),
    .FrameErr   (FrameErr)
  );

  assign cmd.CmdValid   = (state == CMD_ISSUE);
  assign cmd.CmdWrite   = is_write;
  assign cmd.CmdAddress = addr_q;
  assign cmd.CmdData    = data_q;

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      state    <= CMD_OPC;
      byte_cnt <= '0;
      is_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      CmdErr   <= 1'b0;
    end else begin
      state  <= state_nxt;
      CmdErr <= err_set;
      if (wr_load) is_write <= wr_val;
      if (addr_shift) addr_q <= {addr_q[23:0], RxByte};
      if (data_shift) data_q <= {data_q[23:0], RxByte};
      if (data_clr)   data_q <= '0;
      if (state == CMD_OPC)             byte_cnt <= '0;
      else if (addr_shift || data_shift) byte_cnt <= byte_cnt + 2'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_load    = 1'b0;
    wr_val     = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
    data_clr   = 1'b0;
    err_set    = 1'b0;
    case (state)
      CMD_OPC: begin
        if (RxByteValid) begin
          if (RxByte == UART_OPC_WRITE) begin
            wr_load   = 1'b1;
            wr_val    = 1'b1;
            state_nxt = CMD_ADDR;
          end else if (RxByte == UART_OPC_READ) begin
            wr_load   = 1'b1;
            state_nxt = CMD_ADDR;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      CMD_ADDR: begin
        if (FrameErr) begin
          state_nxt = CMD_OPC;
        end else if (RxByteValid) begin
          addr_shift = 1'b1;
          if (byte_cnt == 2'd3) begin
            data_clr  = !is_write;
            state_nxt = is_write ? CMD_DATA : CMD_ISSUE;
          end
        end
      end
      CMD_DATA: begin
        if (FrameErr) begin
          state_nxt = CMD_OPC;
        end else if (RxByteValid) begin
          data_shift = 1'b1;
          if (byte_cnt == 2'd3) state_nxt = CMD_ISSUE;
        end
      end
      CMD_ISSUE: begin
        // A byte landing here is always dropped, even when the handshake completes this cycle.
        if (cmd.CmdReady) state_nxt = CMD_OPC;
        if (RxByteValid)  err_set   = 1'b1;
      end
      default: state_nxt = CMD_OPC;
    endcase
  end

endmodule

// File: tb/tb_lotr_uart_cmd_rx.sv
// Self-checking bench for lotr_uart_cmd_rx with CLKS_PER_BIT=8 and a command-level reference model.
module tb_lotr_uart_cmd_rx;

  localparam int unsigned CPB = 8;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  logic       QClk = 1'b0;
  logic       RstQnnnH;
  logic       UartRx;
  logic       RxByteValid;
  logic [7:0] RxByte;
  logic       FrameErr;
  logic       CmdErr;

  lotr_uart_cmd_rx_if cmd_if ();

  lotr_uart_cmd_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .QClk       (QClk),
    .RstQnnnH   (RstQnnnH),
    .UartRx     (UartRx),
    .cmd        (cmd_if),
    .RxByteValid(RxByteValid),
    .RxByte     (RxByte),
    .FrameErr   (FrameErr),
    .CmdErr     (CmdErr)
  );

  always #5 QClk = ~QClk;

  int compared   = 0;
  int mismatched = 0;
  int n_rxv = 0, n_ferr = 0, n_cerr = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_bytes[$];
  cmd_t got_q[$];
  cmd_t exp_q[$];

  always @(negedge QClk) begin
    cmd_t c;
    if (RxByteValid) begin
      n_rxv++;
      rx_q.push_back(RxByte);
    end
    if (FrameErr) n_ferr++;
    if (CmdErr)   n_cerr++;
    if (cmd_if.CmdValid && cmd_if.CmdReady) begin
      c = {cmd_if.CmdWrite, cmd_if.CmdAddress, cmd_if.CmdData};
      got_q.push_back(c);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge QClk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    UartRx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      UartRx = b[i];
      idle(CPB);
    end
    UartRx = stop_ok;
    idle(CPB);
    UartRx = 1'b1;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    send_byte(w ? 8'h57 : 8'h52, 1'b1);
    exp_bytes.push_back(w ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) begin
      send_byte(a[31-8*i -: 8], 1'b1);
      exp_bytes.push_back(a[31-8*i -: 8]);
    end
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(d[31-8*i -: 8], 1'b1);
        exp_bytes.push_back(d[31-8*i -: 8]);
      end
    end
  endtask

  task automatic test_reset;
    RstQnnnH = 1'b1;
    UartRx = 1'b1;
    cmd_if.CmdReady = 1'b1;
    idle(5);
    @(negedge QClk);
    compared++;
    if ({cmd_if.CmdValid, cmd_if.CmdWrite, RxByteValid, FrameErr, CmdErr} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got %b want 00000",
               {cmd_if.CmdValid, cmd_if.CmdWrite, RxByteValid, FrameErr, CmdErr});
    end
    compared++;
    if ({cmd_if.CmdAddress, cmd_if.CmdData, RxByte} !== 72'h0) begin
      mismatched++;
      $display("FAIL reset_buses: addr %h data %h byte %h want 0",
               cmd_if.CmdAddress, cmd_if.CmdData, RxByte);
    end
    idle(1);
    RstQnnnH = 1'b0;
    idle(10);
  endtask

  task automatic test_write;
    got_q.delete();
    send_cmd(1'b1, 32'h03d02018, 32'hDEADBEEF);
    @(negedge QClk);
    compared++;
    if ({cmd_if.CmdValid, cmd_if.CmdWrite, cmd_if.CmdAddress, cmd_if.CmdData} !== {2'b11, 32'h03d02018, 32'hDEADBEEF}) begin
      mismatched++;
      $display("FAIL write_latency: valid %b write %b addr %h data %h want 1 1 03d02018 deadbeef",
               cmd_if.CmdValid, cmd_if.CmdWrite, cmd_if.CmdAddress, cmd_if.CmdData);
    end
    idle(1);
    @(negedge QClk);
    compared++;
    if (cmd_if.CmdValid !== 1'b0) begin
      mismatched++;
      $display("FAIL write_valid_drop: got %b want 0", cmd_if.CmdValid);
    end
    idle(5);
    compared++;
    if (got_q.size() != 1) begin
      mismatched++;
      $display("FAIL write_count: got %0d want 1", got_q.size());
    end
  endtask

  task automatic test_read;
    got_q.delete();
    send_cmd(1'b0, 32'h03d02018, 32'h12345678);
    @(negedge QClk);
    compared++;
    if ({cmd_if.CmdValid, cmd_if.CmdWrite, cmd_if.CmdAddress, cmd_if.CmdData} !== {2'b10, 32'h03d02018, 32'h0}) begin
      mismatched++;
      $display("FAIL read_cmd: valid %b write %b addr %h data %h want 1 0 03d02018 00000000",
               cmd_if.CmdValid, cmd_if.CmdWrite, cmd_if.CmdAddress, cmd_if.CmdData);
    end
    idle(5);
    compared++;
    if (got_q.size() != 1) begin
      mismatched++;
      $display("FAIL read_count: got %0d want 1", got_q.size());
    end
  endtask

  task automatic test_back_to_back;
    cmd_t e;
    logic w;
    logic [31:0] a, d;
    got_q.delete();
    exp_q.delete();
    rx_q.delete();
    exp_bytes.delete();
    for (int k = 0; k < 8; k++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      e.w = w;
      e.a = a;
      e.d = w ? d : 32'h0;
      exp_q.push_back(e);
      send_cmd(w, a, d);
      idle($urandom_range(0, 3));
    end
    idle(10);
    compared++;
    if (got_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      compared++;
      if (got_q[k] !== exp_q[k]) begin
        mismatched++;
        $display("FAIL b2b_cmd[%0d]: got %b/%h/%h want %b/%h/%h", k,
                 got_q[k].w, got_q[k].a, got_q[k].d, exp_q[k].w, exp_q[k].a, exp_q[k].d);
      end
    end
    compared++;
    if (rx_q != exp_bytes) begin
      mismatched++;
      $display("FAIL b2b_bytes: got %0d bytes want %0d matching bytes", rx_q.size(), exp_bytes.size());
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a;
    logic stable;
    int cerr0;
    got_q.delete();
    a = $urandom;
    cmd_if.CmdReady = 1'b0;
    send_cmd(1'b0, a, 32'h0);
    cerr0 = n_cerr;
    stable = 1'b1;
    fork
      begin
        repeat (200) begin
          @(negedge QClk);
          if (!(cmd_if.CmdValid === 1'b1 && cmd_if.CmdWrite === 1'b0 &&
                cmd_if.CmdAddress === a && cmd_if.CmdData === 32'h0))
            stable = 1'b0;
        end
      end
      begin
        idle(20);
        send_byte(8'h41, 1'b1);
      end
    join
    compared++;
    if (stable !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_stable: got %b want 1 (addr %h)", stable, a);
    end
    compared++;
    if (n_cerr - cerr0 != 1) begin
      mismatched++;
      $display("FAIL bp_cmderr: got %0d want 1", n_cerr - cerr0);
    end
    idle(1);
    cmd_if.CmdReady = 1'b1;
    idle(3);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, a, 32'h0}) begin
      mismatched++;
      $display("FAIL bp_handshake: got %0d cmds want 1 read at %h", got_q.size(), a);
    end
    @(negedge QClk);
    compared++;
    if (cmd_if.CmdValid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_release: valid %b want 0", cmd_if.CmdValid);
    end
    idle(1);
  endtask

  task automatic test_frame_err;
    logic [31:0] a, d;
    int ferr0;
    got_q.delete();
    ferr0 = n_ferr;
    send_byte(8'h57, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(20);
    compared++;
    if (n_ferr - ferr0 != 1) begin
      mismatched++;
      $display("FAIL ferr_pulse: got %0d want 1", n_ferr - ferr0);
    end
    a = $urandom;
    d = $urandom;
    send_cmd(1'b1, a, d);
    idle(5);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, a, d}) begin
      mismatched++;
      $display("FAIL ferr_recover: got %0d cmds want 1 write %h/%h", got_q.size(), a, d);
    end
  endtask

  task automatic test_unknown_opc;
    logic [31:0] a;
    int cerr0, rxv0;
    got_q.delete();
    cerr0 = n_cerr;
    send_byte(8'h4A, 1'b1);
    idle(5);
    compared++;
    if (n_cerr - cerr0 != 1 || got_q.size() != 0) begin
      mismatched++;
      $display("FAIL opc_unknown: cmderr %0d cmds %0d want 1 0", n_cerr - cerr0, got_q.size());
    end
    rxv0 = n_rxv;
    UartRx = 1'b0;
    idle(3);
    UartRx = 1'b1;
    idle(40);
    compared++;
    if (n_rxv != rxv0) begin
      mismatched++;
      $display("FAIL glitch: got %0d bytes want 0", n_rxv - rxv0);
    end
    a = $urandom;
    send_cmd(1'b0, a, 32'h0);
    idle(5);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, a, 32'h0}) begin
      mismatched++;
      $display("FAIL opc_recover: got %0d cmds want 1 read at %h", got_q.size(), a);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a, d;
    int rxv0, ferr0, cerr0;
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'hA5 ^ 8'(i), 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    UartRx = 1'b0;
    idle(CPB);
    UartRx = 1'b1;
    idle(CPB);
    UartRx = 1'b0;
    idle(2);
    RstQnnnH = 1'b1;
    idle(3);
    @(negedge QClk);
    compared++;
    if ({cmd_if.CmdValid, cmd_if.CmdWrite, cmd_if.CmdAddress, cmd_if.CmdData,
         RxByteValid, RxByte, FrameErr, CmdErr} !== '0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: valid %b write %b addr %h data %h byte %h want all 0",
               cmd_if.CmdValid, cmd_if.CmdWrite, cmd_if.CmdAddress, cmd_if.CmdData, RxByte);
    end
    idle(1);
    RstQnnnH = 1'b0;
    rxv0 = n_rxv;
    ferr0 = n_ferr;
    cerr0 = n_cerr;
    idle(12);
    UartRx = 1'b1;
    idle(100);
    compared++;
    if (n_rxv != rxv0 || n_ferr != ferr0 || n_cerr != cerr0) begin
      mismatched++;
      $display("FAIL rst_mid_resync: bytes %0d ferr %0d cmderr %0d want 0 0 0",
               n_rxv - rxv0, n_ferr - ferr0, n_cerr - cerr0);
    end
    got_q.delete();
    a = $urandom;
    d = $urandom;
    send_cmd(1'b1, a, d);
    idle(5);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, a, d}) begin
      mismatched++;
      $display("FAIL rst_mid_recover: got %0d cmds want 1 write %h/%h", got_q.size(), a, d);
    end
  endtask

  initial begin
    RstQnnnH = 1'b1;
    UartRx = 1'b1;
    cmd_if.CmdReady = 1'b1;
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_backpressure;
    test_frame_err;
    test_unknown_opc;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lotr_uart_cmd_rx.md
# lotr_uart_cmd_rx

Device-side UART terminal command receiver for the LOTR FPGA tile. It deserializes 8N1, LSB-first bytes from the host terminal at 115200 baud and parses the terminal write ('W') and read ('R') command frames. It presents each complete command as a single request on a valid/ready interface toward the MMIO/fabric request path. Burst opcodes are outside this block's scope and are rejected as unknown.

## Interface
- CLKS_PER_BIT, 434, QClk cycles per UART bit (50 MHz / 115200); legal range 8..65535
- QClk  in  1  core clock; all logic on rising edge
- RstQnnnH  in  1  synchronous, active-high reset
- UartRx  in  1  serial line from host; idle high; asynchronous to QClk
- CmdValid  out  1  command pending; held until accepted
- CmdReady  in  1  consumer accepts when CmdValid && CmdReady
- CmdWrite  out  1  1 = write ('W'), 0 = read ('R')
- CmdAddress  out  32  command address, MSB byte first on the line
- CmdData  out  32  write data, MSB byte first; 0 for reads
- RxByteValid  out  1  one-cycle pulse per good byte (debug)
- RxByte  out  8  last good byte; valid with RxByteValid
- FrameErr  out  1  one-cycle pulse: stop bit sampled low
- CmdErr  out  1  one-cycle pulse: unknown opcode, or byte dropped while a command is pending

## Operation
- UartRx passes through a 2-flop synchronizer before use; the synchronizer resets to 1.
- Byte FSM, states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: a synced 1→0 edge → START; bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample the line. Low → DATA. High → IDLE (glitch; no pulse).
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, shift LSB first, then → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High: RxByteValid pulse, then → IDLE.
    - Low: FrameErr pulse, byte discarded, → WAIT_HIGH.
  - WAIT_HIGH: stay until the synced line is high, then → IDLE.
- Command FSM, states OPC, ADDR, DATA, ISSUE:
  - OPC: byte 0x57 → ADDR with write=1. Byte 0x52 → ADDR with write=0. Any other byte → CmdErr pulse; stay in OPC.
  - ADDR: 4 bytes, each shifted in as address = {address[23:0], byte}. Write → DATA; read → ISSUE with data = 0.
  - DATA: 4 bytes, shifted the same way as ADDR → ISSUE.
  - ISSUE: CmdValid=1 with CmdWrite, CmdAddress and CmdData stable. Handshake → OPC; CmdValid drops the following cycle.
- FrameErr during ADDR or DATA aborts the partial command → OPC; no request is issued.
- A good byte arriving in ISSUE is dropped and pulses CmdErr. The pending command is unaffected.
- Reset values: CmdValid=0, CmdWrite=0, CmdAddress=0, CmdData=0, RxByteValid=0, RxByte=0, FrameErr=0, CmdErr=0. Both FSMs go to their first state (IDLE, OPC).

## Timing
- Reset is taken on any edge with RstQnnnH=1, including mid-frame or during ISSUE. The pending command is lost. After release, a frame already in flight is ignored until its line returns high; WAIT_HIGH-style resync is entered when the line is low at release.
- Stop-bit sample in cycle N → RxByteValid and RxByte registered in N+1 → command FSM updates in N+2.
- CmdValid asserts in N+2 after the stop bit of the last byte (4th address byte for a read, 4th data byte for a write).
- Back-to-back commands are allowed. CmdValid may re-assert no earlier than the next completed frame.
- Handshake and a new byte in the same cycle in ISSUE: the handshake wins, and the byte is dropped with CmdErr.

## Structure
- lotr_pkg holds:
  - UART_OPC_WRITE = 8'h57 and UART_OPC_READ = 8'h52;
  - typedef enum t_uart_bit_st {IDLE, START, DATA, STOP, WAIT_HIGH};
  - typedef enum t_uart_cmd_st {OPC, ADDR, DATA, ISSUE}.
- Sub-module lotr_uart_rx_byte contains the synchronizer, the byte FSM and the bit/clock counters. It outputs RxByteValid, RxByte and FrameErr.
- The top level holds the command FSM, the byte counter (2 bits) and the address/data shift registers.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Write 'W', 03 d0 20 18, DE AD BE EF, with CmdReady=1 → one CmdValid cycle: CmdWrite=1, CmdAddress=0x03d02018, CmdData=0xDEADBEEF, at N+2 after the last stop bit.
- Read 'R', 03 d0 20 18 → CmdValid: CmdWrite=0, CmdAddress=0x03d02018, CmdData=0.
- Backpressure: hold CmdReady=0 for 200 cycles and send byte 0x41 meanwhile → outputs stable, one CmdErr pulse, then handshake, then OPC.
- Stop bit forced low on the 2nd address byte → FrameErr pulse, no CmdValid; a following full 'W' frame succeeds.
- Opcode 0x4A → CmdErr pulse, no CmdValid; a following 'R' frame succeeds. A 3-cycle low glitch on UartRx → no RxByteValid.
- RstQnnnH pulsed mid data byte 3 → all outputs 0; the next full command decodes correctly.
